// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and default timing.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } seq_state_e;

    localparam int unsigned DEF_NUM_STAGES  = 4;
    localparam int unsigned DEF_STAGE_DELAY = 16;

endpackage

// File: rtl/reset_sequencer_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, deasserts on the second clock edge.
module rst_sync_2ff (
    input  logic clk,
    input  logic rst,
    output logic rst_sync
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= 1'b0;
            sync_q <= meta_q;
        end
    end

    assign rst_sync = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Ordered per-subsystem reset release with soft-reset restart; every output is a flop.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter  int unsigned NUM_STAGES  = DEF_NUM_STAGES,
    parameter  int unsigned STAGE_DELAY = DEF_STAGE_DELAY,
    localparam int unsigned CNT_W       = $clog2(STAGE_DELAY) + 1,
    localparam int unsigned IDX_W       = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  soft_rst_req,
    output logic                  soft_rst_ack,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic [IDX_W-1:0]      stage_idx,
    output logic                  seq_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

    logic                  rst_sync;
    seq_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [NUM_STAGES-1:0] stage_rst_q;
    logic [IDX_W-1:0]      stage_idx_q;
    logic                  seq_done_q;
    logic                  ack_q;

    rst_sync_2ff u_rst_sync (
        .clk      (clk),
        .rst      (rst),
        .rst_sync (rst_sync)
    );

    // Releasing bit 0 first means each release is a left shift filling a zero.
    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            stage_rst_q <= '1;
            stage_idx_q <= '0;
            seq_done_q  <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_HOLD, S_RELEASE: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q       <= '0;
                        stage_rst_q <= stage_rst_q << 1;
                        stage_idx_q <= stage_idx_q + IDX_W'(1);
                        if (stage_idx_q == IDX_LAST) begin
                            state_q    <= S_RUN;
                            seq_done_q <= 1'b1;
                        end else begin
                            state_q <= S_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (soft_rst_req) begin
                        state_q     <= S_HOLD;
                        cnt_q       <= '0;
                        stage_rst_q <= '1;
                        stage_idx_q <= '0;
                        seq_done_q  <= 1'b0;
                        ack_q       <= 1'b1;
                    end
                end
                default: state_q <= S_HOLD;
            endcase
        end
    end

    assign soft_rst_ack = ack_q;
    assign stage_rst    = stage_rst_q;
    assign stage_idx    = stage_idx_q;
    assign seq_done     = seq_done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-up, soft reset, held request, mid-sequence reset, 1-stage build.
module tb_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       soft_rst_req;
    logic       soft_rst_ack;
    logic [3:0] stage_rst;
    logic [2:0] stage_idx;
    logic       seq_done;

    logic       req2;
    logic       ack2;
    logic [0:0] stage_rst2;
    logic [0:0] stage_idx2;
    logic       done2;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = -1;

    reset_sequencer #(.NUM_STAGES(4), .STAGE_DELAY(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .soft_rst_req (soft_rst_req),
        .soft_rst_ack (soft_rst_ack),
        .stage_rst    (stage_rst),
        .stage_idx    (stage_idx),
        .seq_done     (seq_done)
    );

    reset_sequencer #(.NUM_STAGES(1), .STAGE_DELAY(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .soft_rst_req (req2),
        .soft_rst_ack (ack2),
        .stage_rst    (stage_rst2),
        .stage_idx    (stage_idx2),
        .seq_done     (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    // Expected main-DUT outputs at edge n for a sequence whose reference edge is e0.
    task automatic check_main(input int n, input int e0, input bit ack_on);
        logic [3:0] er;
        logic [2:0] ei;
        er = 4'b1111;
        ei = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (n >= e0 + (k + 1) * 16) begin
                er[k] = 1'b0;
                ei    = ei + 3'd1;
            end
        end
        chk("stage_rst", 32'(stage_rst), 32'(er));
        chk("stage_idx", 32'(stage_idx), 32'(ei));
        chk("seq_done", 32'(seq_done), (n >= e0 + 64) ? 32'd1 : 32'd0);
        if (ack_on) chk("soft_rst_ack", 32'(soft_rst_ack), 32'd0);
    endtask

    // Runs up to edge `last`, pulsing the request before edges p1/p2 when p1 >= 0.
    task automatic run_seq(input int e0, input int last, input int p1, input int p2);
        for (int n = edge_n + 1; n <= last; n++) begin
            if (p1 >= 0) soft_rst_req = (n == p1) || (n == p2);
            tick();
            check_main(n, e0, 1'b1);
        end
    endtask

    initial begin
        soft_rst_req = 1'b0;
        req2 = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_stage_rst", 32'(stage_rst), 32'hf);
        chk("rst_stage_idx", 32'(stage_idx), 32'd0);
        chk("rst_seq_done", 32'(seq_done), 32'd0);
        chk("rst_ack", 32'(soft_rst_ack), 32'd0);
        chk("rst_stage_rst_1s", 32'(stage_rst2), 32'd1);

        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        edge_n = -1;

        // Power-up release; single-stage build checked at edges 1 and 2.
        tick();
        check_main(0, 1, 1'b1);
        tick();
        check_main(1, 1, 1'b1);
        chk("s1_stage_rst_e1", 32'(stage_rst2), 32'd1);
        chk("s1_done_e1", 32'(done2), 32'd0);
        tick();
        check_main(2, 1, 1'b1);
        chk("s1_stage_rst_e2", 32'(stage_rst2), 32'd0);
        chk("s1_done_e2", 32'(done2), 32'd1);
        chk("s1_idx_e2", 32'(stage_idx2), 32'd1);
        run_seq(1, 69, -1, -1);

        // Soft reset accepted at edge 70 on both builds.
        soft_rst_req = 1'b1;
        req2 = 1'b1;
        tick();
        chk("soft_ack_e70", 32'(soft_rst_ack), 32'd1);
        chk("soft_stage_rst_e70", 32'(stage_rst), 32'hf);
        chk("soft_idx_e70", 32'(stage_idx), 32'd0);
        chk("soft_done_e70", 32'(seq_done), 32'd0);
        chk("s1_ack_e70", 32'(ack2), 32'd1);
        chk("s1_stage_rst_e70", 32'(stage_rst2), 32'd1);
        soft_rst_req = 1'b0;
        req2 = 1'b0;
        tick();
        check_main(71, 70, 1'b1);
        chk("s1_ack_e71", 32'(ack2), 32'd0);
        chk("s1_done_e71", 32'(done2), 32'd1);
        chk("s1_stage_rst_e71", 32'(stage_rst2), 32'd0);

        // Pulses in HOLD (75) and RELEASE (100) are ignored.
        run_seq(70, 139, 75, 100);

        // Request held high: one ack on acceptance, the next once RUN is re-entered.
        soft_rst_req = 1'b1;
        tick();
        chk("held_ack_e140", 32'(soft_rst_ack), 32'd1);
        chk("held_stage_rst_e140", 32'(stage_rst), 32'hf);
        for (int n = 141; n <= 204; n++) begin
            tick();
            check_main(n, 140, 1'b1);
        end
        tick();
        chk("held_ack_e205", 32'(soft_rst_ack), 32'd1);
        chk("held_stage_rst_e205", 32'(stage_rst), 32'hf);
        chk("held_done_e205", 32'(seq_done), 32'd0);
        soft_rst_req = 1'b0;
        run_seq(205, 235, -1, -1);

        // Board reset mid-RELEASE acts before the next clock edge.
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_stage_rst", 32'(stage_rst), 32'hf);
        chk("mid_rst_idx", 32'(stage_idx), 32'd0);
        chk("mid_rst_done", 32'(seq_done), 32'd0);
        chk("mid_rst_ack", 32'(soft_rst_ack), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        edge_n = -1;
        run_seq(1, 66, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
